// File: rtl/dsram_pkg.sv
// Shared definitions for the data SRAM responder: FSM state encoding, counter width, lane count.
// Pure declarations; no logic, no latency, no backpressure.
package dsram_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;
  localparam int LANES = 4;
endpackage

// File: rtl/dsram_bytemem.sv
// Word-organised SRAM with four byte-enabled write lanes and a registered read port.
// Latency: read data appears one clock after re; writes commit on the same edge. No backpressure.
// Only the read register is reset; array contents survive reset.
module dsram_bytemem
  import dsram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANES-1:0]  we,
  input  logic              re,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_sram_responder.sv
// CPU data-port SRAM responder: one outstanding request, data_ok WAIT_CYCLES+1 cycles after acceptance.
// Backpressure: addr_ok only in IDLE (also in RESP when DSRAM_BACK_TO_BACK_EN is defined); req without addr_ok is dropped.
// Async active-low reset aborts any in-flight request without touching memory.
module data_sram_responder
  import dsram_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

`ifdef DSRAM_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam bit             ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t            state;
  logic [CNT_W-1:0]  waitCnt;
  logic              reqWr;
  logic [ADDR_W-1:0] reqIdx;
  logic [3:0]        reqStrb;
  logic [31:0]       reqData;

  logic              accept;
  logic              goResp;
  logic              opWr;
  logic [ADDR_W-1:0] opIdx;
  logic [3:0]        opStrb;
  logic [31:0]       opData;
  logic [LANES-1:0]  memWe;
  logic              memRe;
  logic              unusedAddr;

  assign accept     = req & addr_ok;
  assign unusedAddr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // With zero wait states the memory op happens on the acceptance edge, so it must use the live inputs.
  always_comb begin
    opWr   = reqWr;
    opIdx  = reqIdx;
    opStrb = reqStrb;
    opData = reqData;
    if (accept) begin
      opWr   = wr;
      opIdx  = addr[ADDR_W+1:2];
      opStrb = wstrb;
      opData = wdata;
    end
    goResp = accept ? ZERO_WAIT : ((state == WAIT) && (waitCnt == CNT_W'(1)));
    memWe  = (goResp && opWr) ? opStrb : '0;
    memRe  = goResp && !opWr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      addr_ok <= 1'b0;
      data_ok <= 1'b0;
      reqWr   <= 1'b0;
      reqIdx  <= '0;
      reqStrb <= '0;
      reqData <= '0;
    end else begin
      addr_ok <= 1'b0;
      data_ok <= 1'b0;
      if (accept) begin
        reqWr   <= wr;
        reqIdx  <= addr[ADDR_W+1:2];
        reqStrb <= wstrb;
        reqData <= wdata;
        waitCnt <= WAIT_INIT;
        if (ZERO_WAIT) begin
          state   <= RESP;
          data_ok <= 1'b1;
          addr_ok <= B2B;
        end else begin
          state <= WAIT;
        end
      end else begin
        unique case (state)
          IDLE: addr_ok <= 1'b1;
          WAIT: begin
            waitCnt <= waitCnt - CNT_W'(1);
            if (waitCnt == CNT_W'(1)) begin
              state   <= RESP;
              data_ok <= 1'b1;
              addr_ok <= B2B;
            end
          end
          RESP: begin
            state   <= IDLE;
            addr_ok <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  dsram_bytemem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (memWe),
    .re    (memRe),
    .idx   (opIdx),
    .wdata (opData),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: WAIT_CYCLES=2 instance for function/reset, WAIT_CYCLES=0 instance for throughput.
// Throughput expectation follows DSRAM_BACK_TO_BACK_EN when defined.
module tb_data_sram_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        req0;
  logic        addrOk0, dataOk0;
  logic [31:0] rdata0;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  data_sram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .wr(1'b0), .addr(32'h0), .wstrb(4'h0), .wdata(32'h0),
    .addr_ok(addrOk0), .data_ok(dataOk0), .rdata(rdata0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Issue one request as soon as addr_ok allows; returns the rdata seen with data_ok.
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int expLat, output logic [31:0] rd);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!addr_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_aok"}, {31'b0, addr_ok}, 32'd1);
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!data_ok && lat < 20);
    chk({tag, "_lat"}, lat, expLat);
    rd = rdata;
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, data_ok}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          pulses;
    logic        sawDok;
    rst = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0; req0 = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_aok",   {31'b0, addr_ok}, 32'd0);
    chk("rst_dok",   {31'b0, data_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_aok", {31'b0, addr_ok}, 32'd1);

    // Full-word store then load, 3-cycle response
    xact("st10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 3, rd);
    xact("ld10", 1'b0, 32'h10, 4'h0, 32'h0, 3, rd);
    chk("ld10_data", rd, 32'hDEADBEEF);

    // Single-lane store at byte address 0x12 hits lane 2 of word 0x10
    xact("st12", 1'b1, 32'h12, 4'b0100, 32'h00AA0000, 3, rd);
    chk("st_keeps_rdata", rdata, 32'hDEADBEEF);
    xact("ld10b", 1'b0, 32'h10, 4'h0, 32'h0, 3, rd);
    chk("ld10b_data", rd, 32'hDEAABEEF);

    // Index wraps: 0x1000 aliases word 0 with ADDR_W=10
    xact("st1000", 1'b1, 32'h1000, 4'hF, 32'h12345678, 3, rd);
    xact("ld0", 1'b0, 32'h0, 4'h0, 32'h0, 3, rd);
    chk("wrap_data", rd, 32'h12345678);

    // Empty strobe: still responds, memory unchanged
    xact("st30", 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 3, rd);
    xact("st30z", 1'b1, 32'h30, 4'h0, 32'h0BADBAD0, 3, rd);
    xact("ld30", 1'b0, 32'h30, 4'h0, 32'h0, 3, rd);
    chk("zstrb_data", rd, 32'hCAFEF00D);

    // Reset during WAIT aborts the store
    xact("st20", 1'b1, 32'h20, 4'hF, 32'h5A5A5A5A, 3, rd);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h20; wstrb = 4'hF; wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sawDok = 1'b0;
    @(negedge clk);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_aok", {31'b0, addr_ok}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sawDok = sawDok | data_ok;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_aok_back", {31'b0, addr_ok}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sawDok = sawDok | data_ok;
    end
    chk("abort_no_dok", {31'b0, sawDok}, 32'd0);
    xact("ld20", 1'b0, 32'h20, 4'h0, 32'h0, 3, rd);
    chk("abort_data", rd, 32'h5A5A5A5A);

    // Zero-wait throughput with req held high
    @(negedge clk);
    req0 = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) chk("tput_first", {31'b0, dataOk0}, 32'd1);
      if (dataOk0) pulses++;
    end
    req0 = 1'b0;
`ifdef DSRAM_BACK_TO_BACK_EN
    chk("tput_pulses", pulses, 32'd8);
`else
    chk("tput_pulses", pulses, 32'd4);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 Parameter ADDR_W, default 10; word-address bits, giving 2^ADDR_W words of 32 bits.
REQ-002 Parameter WAIT_CYCLES, default 2; wait states inserted between request acceptance and response, legal range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  CPU data request valid.
REQ-006 wr  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] and upper bits ignored.
REQ-008 wstrb  input  4  byte-lane write enables, lane i = wdata[8i+7:8i]; ignored on loads.
REQ-009 wdata  input  32  store data, already lane-aligned by the CPU.
REQ-010 addr_ok  output  1  request accepted this cycle when req & addr_ok.
REQ-011 data_ok  output  1  one-cycle response pulse for the oldest accepted request.
REQ-012 rdata  output  32  load data, valid while data_ok=1 on a load.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 In IDLE, addr_ok SHALL be 1; on req=1, addr, wr, wstrb and wdata SHALL be latched and a wait counter loaded with WAIT_CYCLES.
REQ-015 From IDLE, on acceptance, the FSM SHALL go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-016 In WAIT, addr_ok SHALL be 0 and the counter SHALL decrement each cycle; on the cycle it reads 1 the FSM SHALL go to RESP.
REQ-017 data_ok SHALL be 1 exactly in RESP, which lasts one cycle, so data_ok rises WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-018 On the edge entering RESP, a store SHALL commit the enabled byte lanes to memory and a load SHALL register mem[index] into rdata.
REQ-019 A store with wstrb=4'b0000 SHALL leave memory unchanged and still produce data_ok.
REQ-020 rdata SHALL hold its last loaded value outside load responses; stores SHALL NOT change rdata.
REQ-021 From RESP, the FSM SHALL return to IDLE, unless REQ-027 applies.
REQ-022 At most one request SHALL be outstanding; req while addr_ok=0 SHALL be ignored and not queued.
REQ-023 A load following a store to the same word SHALL return the post-store data.
REQ-024 Index arithmetic SHALL wrap modulo 2^ADDR_W; no error response exists.

Reset
REQ-025 While rst=0: FSM forced to IDLE, counter 0, addr_ok 0, data_ok 0, rdata 32'h0; memory contents not reset.
REQ-026 Reset asserted in WAIT SHALL abort the transaction: no memory write and no data_ok. addr_ok SHALL return to 1 in the first cycle after rst deasserts.

Configuration
REQ-027 With macro DSRAM_BACK_TO_BACK_EN defined, addr_ok SHALL also be 1 in RESP. A request accepted in RESP SHALL be handled as if accepted in IDLE, giving one request per WAIT_CYCLES+1 cycles. Without the macro, addr_ok SHALL be 1 only in IDLE, giving one request per WAIT_CYCLES+2 cycles.

Structure
REQ-028 The shared package dsram_pkg SHALL hold the state encoding (IDLE/WAIT/RESP), the counter width constant (4) and the lane count (4).
REQ-029 The storage SHALL be a sub-module dsram_bytemem: a 2^ADDR_W x 32 array with four byte-enabled write lanes and a registered read port; the FSM, counter and handshake SHALL stay in the top module.

Verification
REQ-030 WAIT_CYCLES=2: store addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF accepted at cycle 0 -> data_ok=1 at cycle 3 only; then a load of 0x10 -> rdata=0xDEADBEEF with data_ok 3 cycles after its acceptance.
REQ-031 After REQ-030, store 0x12 with wstrb=4'b0100, wdata=0x00AA0000, then load 0x10 -> rdata=0xDEAABEEF.
REQ-032 WAIT_CYCLES=0: req held high, wr=0 -> data_ok every 2nd cycle without the macro, every cycle with DSRAM_BACK_TO_BACK_EN.
REQ-033 ADDR_W=10: store 0x1000 with wdata=0x12345678, then load 0x0000 -> rdata=0x12345678 (wrap).
REQ-034 rst pulsed low in WAIT of a store to 0x20 -> no data_ok; a later load of 0x20 returns the prior contents; rdata=0 during reset.
REQ-035 Store with wstrb=0 to 0x30 -> data_ok pulses, and a later load of 0x30 returns unchanged data.
